// File: rtl/chunk_deser_pkg.sv
// Shared types and default sizes for the chunk deserializer that feeds
// the 3x3 parity/AND reduction tree.
package chunk_deser_pkg;

  localparam int CHUNK_W    = 3;
  localparam int NUM_CHUNKS = 3;
  localparam int WIDTH      = CHUNK_W * NUM_CHUNKS;

  // FILL assembles a word; DROP discards the rest of an over-long frame
  typedef enum logic {
    FILL = 1'b0,
    DROP = 1'b1
  } state_t;

endpackage

// File: rtl/chunk_deser_out_reg.sv
// One-entry valid/ready holding register for assembled words.
// A new word may load in the same cycle the current one is handed off,
// which gives full throughput without a bubble.  Also counts handed-off
// words, wrapping at 2^CNT_W.
module chunk_deser_out_reg #(
  parameter int WIDTH = 9,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] word_cnt,
  output logic             can_load
);

  logic handshake;

  assign handshake = out_valid && out_ready;
  assign can_load  = !out_valid || out_ready;

  // Hold, replace or retire the pending word and count each handoff
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      word_cnt  <= '0;
    end else begin
      if (handshake) begin
        word_cnt <= word_cnt + CNT_W'(1);
      end
      if (load) begin
        out_valid <= 1'b1;
        out_data  <= load_data;
      end else if (handshake) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/chunk_deserializer.sv
// Collects NUM_CHUNKS framed beats of CHUNK_W bits into one word, first
// beat in the MSBs, and hands it downstream through a registered
// valid/ready stage.  Frames that end early or run long are flagged with
// one-cycle error pulses and discarded.  NUM_CHUNKS must be at least 2.
module chunk_deserializer
  import chunk_deser_pkg::*;
#(
  parameter int CHUNK_W    = chunk_deser_pkg::CHUNK_W,
  parameter int NUM_CHUNKS = chunk_deser_pkg::NUM_CHUNKS,
  parameter int CNT_W      = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [CHUNK_W-1:0]            in_data,
  input  logic                          in_last,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [CHUNK_W*NUM_CHUNKS-1:0] out_data,
  output logic                          err_short,
  output logic                          err_long,
  output logic [CNT_W-1:0]              word_cnt
);

  localparam int WIDTH = CHUNK_W * NUM_CHUNKS;
  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] beat_idx;
  logic [IDX_W-1:0] idx_next;
  logic [WIDTH-1:0] assembly;
  logic [WIDTH-1:0] assembly_next;
  logic [WIDTH-1:0] shifted;
  logic             load;
  logic             can_load;
  logic             short_next;
  logic             long_next;

  // Earlier beats sit in the low bits, so appending the new beat at the
  // bottom leaves the first beat in the MSBs once the word is complete.
  assign shifted = {assembly[WIDTH-CHUNK_W-1:0], in_data};

  // Next-state, beat acceptance and word/error decisions
  always_comb begin
    state_next    = state;
    idx_next      = beat_idx;
    assembly_next = assembly;
    in_ready      = 1'b0;
    load          = 1'b0;
    short_next    = 1'b0;
    long_next     = 1'b0;
    case (state)
      FILL: begin
        if (beat_idx != LAST_IDX) begin
          in_ready = 1'b1;
          if (in_valid) begin
            if (in_last) begin
              short_next    = 1'b1;
              idx_next      = '0;
              assembly_next = '0;
            end else begin
              assembly_next = shifted;
              idx_next      = beat_idx + IDX_W'(1);
            end
          end
        end else begin
          // The final beat can only be taken when the output slot frees up
          // this cycle, hence the combinational path from out_ready.
          in_ready = can_load;
          if (in_valid && can_load) begin
            idx_next      = '0;
            assembly_next = '0;
            if (in_last) begin
              load = 1'b1;
            end else begin
              long_next  = 1'b1;
              state_next = DROP;
            end
          end
        end
      end
      DROP: begin
        in_ready = 1'b1;
        if (in_valid && in_last) begin
          state_next = FILL;
          idx_next   = '0;
        end
      end
      default: begin
        state_next = FILL;
      end
    endcase
  end

  // State, beat index, assembly register and registered error pulses
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= FILL;
      beat_idx  <= '0;
      assembly  <= '0;
      err_short <= 1'b0;
      err_long  <= 1'b0;
    end else begin
      state     <= state_next;
      beat_idx  <= idx_next;
      assembly  <= assembly_next;
      err_short <= short_next;
      err_long  <= long_next;
    end
  end

  chunk_deser_out_reg #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (shifted),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .word_cnt  (word_cnt),
    .can_load  (can_load)
  );

  // An offered beat must stay offered until it is taken
  property p_hold_valid;
    @(posedge clk) disable iff (!rst_n) (in_valid && !in_ready) |=> in_valid;
  endproperty
  a_hold_valid: assert property (p_hold_valid);

endmodule
